// File: rtl/wspr_cfg_loader_if.sv
// Host configuration bus for wspr_cfg_loader: async strobes, byte bus and frame status.
interface wspr_cfg_loader_if #(
  parameter int BYTE_W    = 8,
  parameter int NUM_BYTES = 8
);
  logic                            cfg_valid_async;
  logic                            cfg_start_async;
  logic                            rf_start_async;
  logic [BYTE_W-1:0]               cfg_data;
  logic [NUM_BYTES*BYTE_W-1:0]     cfg_word;
  logic                            cfg_ready;
  logic                            cfg_err;
  logic [$clog2(NUM_BYTES+2)-1:0]  byte_cnt;
  logic                            rf_start;

  modport master (
    output cfg_valid_async, cfg_start_async, rf_start_async, cfg_data,
    input  cfg_word, cfg_ready, cfg_err, byte_cnt, rf_start
  );

  modport slave (
    input  cfg_valid_async, cfg_start_async, rf_start_async, cfg_data,
    output cfg_word, cfg_ready, cfg_err, byte_cnt, rf_start
  );
endinterface

// File: rtl/wspr_cfg_loader.sv
// Synchronises async host strobes and assembles NUM_BYTES config bytes into cfg_word.
// Optional feature: define WSPR_CFG_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module wspr_cfg_loader #(
  parameter int SYNC_STAGES = 3,
  parameter int BYTE_W      = 8,
  parameter int NUM_BYTES   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  wspr_cfg_loader_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_BYTES+2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BYTES-1);
  localparam logic [CNT_W-1:0] CNT_CSUM = CNT_W'(NUM_BYTES);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(NUM_BYTES+1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  logic [SYNC_STAGES-1:0]      valid_sync, start_sync, rf_sync, fill_sync;
  logic                        valid_prev, start_prev;
  logic                        filled, valid_s, start_s, valid_pls, start_pls;
  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [NUM_BYTES*BYTE_W-1:0] word_q;
  logic                        wr_en;
`ifdef WSPR_CFG_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]           csum_q, csum_d;
`endif

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_SAT) ? CNT_SAT : c + CNT_W'(1);
  endfunction

  // Synchroniser and edge-detect stage. fill_sync marks when the chain output
  // holds a real post-reset sample; until then prev is forced high so an input
  // already asserted at reset release never looks like a rising edge.
  assign filled  = fill_sync[SYNC_STAGES-1];
  assign valid_s = valid_sync[SYNC_STAGES-1];
  assign start_s = start_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_sync <= '0;
      start_sync <= '0;
      rf_sync    <= '0;
      fill_sync  <= '0;
      valid_prev <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      valid_sync <= {valid_sync[SYNC_STAGES-2:0], bus.cfg_valid_async};
      start_sync <= {start_sync[SYNC_STAGES-2:0], bus.cfg_start_async};
      rf_sync    <= {rf_sync[SYNC_STAGES-2:0], bus.rf_start_async};
      fill_sync  <= {fill_sync[SYNC_STAGES-2:0], 1'b1};
      valid_prev <= valid_s | ~filled;
      start_prev <= start_s | ~filled;
    end
  end

  assign valid_pls = filled & valid_s & ~valid_prev;
  assign start_pls = filled & start_s & ~start_prev;

  // Frame FSM stage: start pre-empts everything, including a coincident byte.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
`ifdef WSPR_CFG_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    if (start_pls) begin
      state_d = LOAD;
      cnt_d   = '0;
`ifdef WSPR_CFG_LOADER_CHECKSUM_EN
      csum_d  = '0;
`endif
    end else if (valid_pls) begin
      case (state_q)
        LOAD: begin
          cnt_d = cnt_inc(cnt_q);
`ifdef WSPR_CFG_LOADER_CHECKSUM_EN
          if (cnt_q == CNT_CSUM) begin
            state_d = (bus.cfg_data == csum_q) ? DONE : ERR;
          end else begin
            wr_en  = 1'b1;
            csum_d = csum_q ^ bus.cfg_data;
          end
`else
          wr_en = 1'b1;
          if (cnt_q == CNT_LAST) state_d = DONE;
`endif
        end
        DONE: begin
          state_d = ERR;
          cnt_d   = CNT_SAT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
`ifdef WSPR_CFG_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef WSPR_CFG_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wr_en && cnt_q == CNT_W'(i)) word_q[i*BYTE_W +: BYTE_W] <= bus.cfg_data;
      end
    end
  end

  assign bus.cfg_word  = word_q;
  assign bus.cfg_ready = (state_q == DONE);
  assign bus.cfg_err   = (state_q == ERR);
  assign bus.byte_cnt  = cnt_q;
  assign bus.rf_start  = rf_sync[SYNC_STAGES-1];

endmodule

// File: tb/tb_wspr_cfg_loader.sv
// Self-checking bench for wspr_cfg_loader (NUM_BYTES=4, BYTE_W=8, SYNC_STAGES=3).
module tb_wspr_cfg_loader;
  localparam int S = 3;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nerr = 0;
  int   nchk = 0;

  always #5 clk = ~clk;

  wspr_cfg_loader_if #(.BYTE_W(8), .NUM_BYTES(N)) bus ();

  wspr_cfg_loader #(.SYNC_STAGES(S), .BYTE_W(8), .NUM_BYTES(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Transaction-level reference: frame contents and status after each host event.
  logic [31:0] m_word;
  logic        m_ready, m_err, m_load;
  logic [2:0]  m_cnt;
  logic [7:0]  m_csum;

  function automatic void m_reset();
    m_word = '0; m_ready = 0; m_err = 0; m_load = 0; m_cnt = 0; m_csum = 0;
  endfunction

  function automatic void m_start();
    m_load = 1; m_ready = 0; m_err = 0; m_cnt = 0; m_csum = 0;
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    if (m_load) begin
`ifdef WSPR_CFG_LOADER_CHECKSUM_EN
      if (m_cnt < N) begin
        m_word[int'(m_cnt)*8 +: 8] = b;
        m_csum = m_csum ^ b;
        m_cnt  = m_cnt + 1;
      end else begin
        m_cnt  = N + 1;
        m_load = 0;
        if (b == m_csum) m_ready = 1; else m_err = 1;
      end
`else
      m_word[int'(m_cnt)*8 +: 8] = b;
      m_cnt = m_cnt + 1;
      if (m_cnt == N) begin m_load = 0; m_ready = 1; end
`endif
    end else if (m_ready) begin
      m_ready = 0; m_err = 1; m_cnt = N + 1;
    end
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    bus.cfg_start_async = 1'b1;
    repeat (S+2) @(negedge clk);
    bus.cfg_start_async = 1'b0;
    repeat (S+1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.cfg_data = b;
    bus.cfg_valid_async = 1'b1;
    repeat (S+2) @(negedge clk);
    bus.cfg_valid_async = 1'b0;
    repeat (S+1) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.cfg_valid_async = 0; bus.cfg_start_async = 0; bus.rf_start_async = 0; bus.cfg_data = 0;
    rst_n = 0;
    m_reset();
    repeat (3) @(negedge clk);
    nchk++;
    if ({bus.cfg_word, bus.cfg_ready, bus.cfg_err, bus.byte_cnt, bus.rf_start} !== 38'd0) begin
      nerr++;
      $display("FAIL reset_state: got %h want 0",
               {bus.cfg_word, bus.cfg_ready, bus.cfg_err, bus.byte_cnt, bus.rf_start});
    end
    rst_n = 1;
    repeat (S+2) @(negedge clk);
  endtask

  task automatic test_rf_start();
    @(negedge clk);
    bus.rf_start_async = 1;
    @(posedge clk); #1;
    nchk++; if (bus.rf_start !== 1'b0) begin nerr++; $display("FAIL rf_k: got %b want 0", bus.rf_start); end
    @(posedge clk); #1;
    nchk++; if (bus.rf_start !== 1'b0) begin nerr++; $display("FAIL rf_k1: got %b want 0", bus.rf_start); end
    @(posedge clk); #1;
    nchk++; if (bus.rf_start !== 1'b1) begin nerr++; $display("FAIL rf_k2: got %b want 1", bus.rf_start); end
    @(negedge clk);
    bus.rf_start_async = 0;
    repeat (S+1) @(negedge clk);
    nchk++; if (bus.rf_start !== 1'b0) begin nerr++; $display("FAIL rf_low: got %b want 0", bus.rf_start); end
  endtask

  task automatic test_full_frame();
    logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    pulse_start(); m_start();
    nchk++;
    if (bus.byte_cnt !== 3'd0 || bus.cfg_ready !== 1'b0) begin
      nerr++; $display("FAIL frame_start: cnt %0d ready %b want 0 0", bus.byte_cnt, bus.cfg_ready);
    end
    foreach (bytes[i]) begin
      send_byte(bytes[i]); m_byte(bytes[i]);
      nchk++;
      if ({bus.cfg_word, bus.cfg_ready, bus.cfg_err, bus.byte_cnt} !== {m_word, m_ready, m_err, m_cnt}) begin
        nerr++;
        $display("FAIL frame_byte%0d: got %h want %h", i,
                 {bus.cfg_word, bus.cfg_ready, bus.cfg_err, bus.byte_cnt}, {m_word, m_ready, m_err, m_cnt});
      end
    end
`ifndef WSPR_CFG_LOADER_CHECKSUM_EN
    nchk++;
    if (bus.cfg_word !== 32'h44332211 || bus.cfg_ready !== 1'b1 || bus.byte_cnt !== 3'd4 || bus.cfg_err !== 1'b0) begin
      nerr++;
      $display("FAIL frame_const: word %h ready %b cnt %0d err %b want 44332211 1 4 0",
               bus.cfg_word, bus.cfg_ready, bus.byte_cnt, bus.cfg_err);
    end
`endif
  endtask

  task automatic test_latency();
    pulse_start(); m_start();
    @(negedge clk);
    bus.cfg_data = 8'hA5;
    bus.cfg_valid_async = 1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    nchk++; if (bus.byte_cnt !== 3'd0) begin nerr++; $display("FAIL lat_k2: got %0d want 0", bus.byte_cnt); end
    @(posedge clk); #1;
    nchk++; if (bus.byte_cnt !== 3'd1) begin nerr++; $display("FAIL lat_k3: got %0d want 1", bus.byte_cnt); end
    repeat (S) @(negedge clk);
    bus.cfg_valid_async = 0;
    repeat (S+1) @(negedge clk);
    m_byte(8'hA5);
    nchk++;
    if (bus.cfg_word[7:0] !== 8'hA5) begin nerr++; $display("FAIL lat_data: got %h want a5", bus.cfg_word[7:0]); end
  endtask

  task automatic test_overrun();
    logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    pulse_start(); m_start();
    foreach (bytes[i]) begin send_byte(bytes[i]); m_byte(bytes[i]); end
    send_byte(8'h55); m_byte(8'h55);
    nchk++;
    if ({bus.cfg_word, bus.cfg_ready, bus.cfg_err, bus.byte_cnt} !== {m_word, m_ready, m_err, m_cnt}) begin
      nerr++;
      $display("FAIL overrun_model: got %h want %h",
               {bus.cfg_word, bus.cfg_ready, bus.cfg_err, bus.byte_cnt}, {m_word, m_ready, m_err, m_cnt});
    end
`ifndef WSPR_CFG_LOADER_CHECKSUM_EN
    nchk++;
    if (bus.cfg_word !== 32'h44332211 || bus.cfg_err !== 1'b1 || bus.cfg_ready !== 1'b0 || bus.byte_cnt !== 3'd5) begin
      nerr++;
      $display("FAIL overrun_const: word %h err %b ready %b cnt %0d want 44332211 1 0 5",
               bus.cfg_word, bus.cfg_err, bus.cfg_ready, bus.byte_cnt);
    end
`endif
    send_byte(8'h66); m_byte(8'h66);
    nchk++;
    if ({bus.cfg_word, bus.cfg_ready, bus.cfg_err, bus.byte_cnt} !== {m_word, m_ready, m_err, m_cnt}) begin
      nerr++;
      $display("FAIL err_sticky: got %h want %h",
               {bus.cfg_word, bus.cfg_ready, bus.cfg_err, bus.byte_cnt}, {m_word, m_ready, m_err, m_cnt});
    end
    pulse_start(); m_start();
    nchk++;
    if ({bus.cfg_word, bus.cfg_ready, bus.cfg_err, bus.byte_cnt} !== {m_word, m_ready, m_err, m_cnt}) begin
      nerr++;
      $display("FAIL err_restart: got %h want %h",
               {bus.cfg_word, bus.cfg_ready, bus.cfg_err, bus.byte_cnt}, {m_word, m_ready, m_err, m_cnt});
    end
  endtask

  task automatic test_start_valid_same();
    @(negedge clk);
    bus.cfg_data = 8'h99;
    bus.cfg_valid_async = 1;
    bus.cfg_start_async = 1;
    repeat (S+2) @(negedge clk);
    bus.cfg_valid_async = 0;
    bus.cfg_start_async = 0;
    repeat (S+1) @(negedge clk);
    m_start();
    nchk++;
    if (bus.byte_cnt !== 3'd0) begin nerr++; $display("FAIL same_edge_cnt: got %0d want 0", bus.byte_cnt); end
    for (int i = 0; i < N; i++) begin
      send_byte(8'hA1 + 8'(i)); m_byte(8'hA1 + 8'(i));
    end
    nchk++;
    if ({bus.cfg_word, bus.cfg_ready, bus.cfg_err, bus.byte_cnt} !== {m_word, m_ready, m_err, m_cnt}) begin
      nerr++;
      $display("FAIL same_edge_model: got %h want %h",
               {bus.cfg_word, bus.cfg_ready, bus.cfg_err, bus.byte_cnt}, {m_word, m_ready, m_err, m_cnt});
    end
`ifndef WSPR_CFG_LOADER_CHECKSUM_EN
    nchk++;
    if (bus.cfg_word !== 32'hA4A3A2A1 || bus.byte_cnt !== 3'd4) begin
      nerr++; $display("FAIL same_edge_const: word %h cnt %0d want a4a3a2a1 4", bus.cfg_word, bus.byte_cnt);
    end
`endif
  endtask

  task automatic test_reset_midframe();
    pulse_start(); m_start();
    send_byte(8'h5A); m_byte(8'h5A);
    send_byte(8'hC3); m_byte(8'hC3);
    @(negedge clk); #2;
    rst_n = 0; m_reset();
    #1;
    nchk++;
    if ({bus.cfg_word, bus.cfg_ready, bus.cfg_err, bus.byte_cnt} !== 37'd0) begin
      nerr++; $display("FAIL async_abort: got %h want 0", {bus.cfg_word, bus.cfg_ready, bus.cfg_err, bus.byte_cnt});
    end
    bus.cfg_data = 8'h77;
    bus.cfg_valid_async = 1;
    bus.cfg_start_async = 1;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (8) @(negedge clk);
    nchk++;
    if ({bus.cfg_word, bus.cfg_ready, bus.cfg_err, bus.byte_cnt, bus.rf_start} !== 38'd0) begin
      nerr++;
      $display("FAIL release_high: got %h want 0",
               {bus.cfg_word, bus.cfg_ready, bus.cfg_err, bus.byte_cnt, bus.rf_start});
    end
    bus.cfg_valid_async = 0;
    bus.cfg_start_async = 0;
    repeat (S+1) @(negedge clk);
    send_byte(8'h77); m_byte(8'h77);
    nchk++;
    if ({bus.cfg_word, bus.cfg_ready, bus.cfg_err, bus.byte_cnt} !== {m_word, m_ready, m_err, m_cnt}) begin
      nerr++;
      $display("FAIL idle_ignore: got %h want %h",
               {bus.cfg_word, bus.cfg_ready, bus.cfg_err, bus.byte_cnt}, {m_word, m_ready, m_err, m_cnt});
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(3, 0) != 0) begin pulse_start(); m_start(); end
      for (int j = 0; j < int'($urandom_range(6, 0)); j++) begin
        b = 8'($urandom);
        send_byte(b); m_byte(b);
        nchk++;
        if ({bus.cfg_word, bus.cfg_ready, bus.cfg_err, bus.byte_cnt} !== {m_word, m_ready, m_err, m_cnt}) begin
          nerr++;
          $display("FAIL rand_f%0d_b%0d: got %h want %h", f, j,
                   {bus.cfg_word, bus.cfg_ready, bus.cfg_err, bus.byte_cnt}, {m_word, m_ready, m_err, m_cnt});
        end
        nchk++;
        if (bus.cfg_ready && bus.cfg_err) begin
          nerr++; $display("FAIL rand_excl: got ready=1 err=1 want not both");
        end
      end
    end
  endtask

`ifdef WSPR_CFG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    pulse_start(); m_start();
    foreach (bytes[i]) begin send_byte(bytes[i]); m_byte(bytes[i]); end
    send_byte(8'h44); m_byte(8'h44);
    nchk++;
    if (bus.cfg_ready !== 1'b1 || bus.cfg_err !== 1'b0 || bus.cfg_word !== 32'h44332211 || bus.byte_cnt !== 3'd5) begin
      nerr++;
      $display("FAIL csum_ok: ready %b err %b word %h cnt %0d want 1 0 44332211 5",
               bus.cfg_ready, bus.cfg_err, bus.cfg_word, bus.byte_cnt);
    end
    pulse_start(); m_start();
    foreach (bytes[i]) begin send_byte(bytes[i]); m_byte(bytes[i]); end
    send_byte(8'h45); m_byte(8'h45);
    nchk++;
    if (bus.cfg_ready !== 1'b0 || bus.cfg_err !== 1'b1) begin
      nerr++; $display("FAIL csum_bad: ready %b err %b want 0 1", bus.cfg_ready, bus.cfg_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rf_start();
    test_full_frame();
    test_latency();
    test_overrun();
    test_start_valid_same();
    test_reset_midframe();
`ifdef WSPR_CFG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/wspr_cfg_loader.md
WSPR_CFG_LOADER -- requirements
Module: wspr_cfg_loader

Interface
REQ-001 Parameter SYNC_STAGES, default 3, sets the synchroniser flop count per async input; legal range 2..4.
REQ-002 Parameter BYTE_W, default 8, sets the config byte width.
REQ-003 Parameter NUM_BYTES, default 8, sets the number of payload bytes per config frame; legal range 1..32.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cfg_valid_async  in  1  async byte strobe; a byte is taken on each rising edge.
REQ-007 cfg_start_async  in  1  async frame start; a frame begins on each rising edge.
REQ-008 rf_start_async  in  1  async RF enable level.
REQ-009 cfg_data  in  BYTE_W  byte bus; the host holds it stable from before the strobe rise until SYNC_STAGES+1 clocks after it.
REQ-010 cfg_word  out  NUM_BYTES*BYTE_W  assembled frame; byte 0 sits at the LSBs.
REQ-011 cfg_ready  out  1  complete, valid frame is held in cfg_word.
REQ-012 cfg_err  out  1  frame error (overrun, or checksum fail when enabled).
REQ-013 byte_cnt  out  $clog2(NUM_BYTES+2)  bytes accepted in the current frame.
REQ-014 rf_start  out  1  synchronised rf_start_async level.

Function
REQ-015 Each async input SHALL pass through a SYNC_STAGES-deep flop chain; an input first sampled high at edge k SHALL appear at the chain output after edge k+SYNC_STAGES-1.
REQ-016 The valid and start edge pulses SHALL equal (sync output AND NOT the registered previous sync output), one clock wide; an input first sampled high at edge k SHALL take effect at edge k+SYNC_STAGES.
REQ-017 rf_start SHALL equal the synchroniser chain output directly, with no edge detection.
REQ-018 FSM states: IDLE, LOAD, DONE, ERR.
REQ-019 A start pulse in any state SHALL move the FSM to LOAD, clear byte_cnt, cfg_ready and cfg_err, and leave cfg_word unchanged.
REQ-020 In LOAD, a valid pulse SHALL write cfg_data into slot byte_cnt and increment byte_cnt.
REQ-021 When LOAD accepts byte NUM_BYTES-1, the FSM SHALL enter DONE on the same edge and cfg_ready SHALL be 1 from the next cycle.
REQ-022 A valid pulse in IDLE SHALL be ignored, with no write and no count change.
REQ-023 A valid pulse in DONE (overrun) SHALL move the FSM to ERR, set cfg_err=1, clear cfg_ready, leave cfg_word unchanged and saturate byte_cnt at NUM_BYTES+1.
REQ-024 ERR SHALL be left only by a start pulse or by reset.
REQ-025 A start pulse and a valid pulse on the same edge: start wins and the byte is dropped.
REQ-026 cfg_word bytes not written in the current frame SHALL hold their previous values.
REQ-027 cfg_ready and cfg_err SHALL never both be 1.

Reset
REQ-028 While rst_n=0, all synchroniser and edge flops SHALL be 0, FSM=IDLE, cfg_word=0, byte_cnt=0, cfg_ready=0, cfg_err=0 and rf_start=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately, asynchronously; after release the block SHALL require a new start pulse.
REQ-030 An async input already high at reset release SHALL NOT generate an edge pulse.

Configuration
REQ-031 Macro WSPR_CFG_LOADER_CHECKSUM_EN:
- Defined: each frame carries one extra byte, the XOR of all payload bytes; byte_cnt counts to NUM_BYTES+1.
- On checksum match, the FSM enters DONE.
- On mismatch, the FSM enters ERR with cfg_err=1.
- The checksum byte is not stored in cfg_word.
- Not defined: no checksum byte; the FSM enters DONE after NUM_BYTES bytes.

Verification (NUM_BYTES=4, BYTE_W=8, SYNC_STAGES=3, macro undefined unless stated)
REQ-032 Start, then bytes 0x11,0x22,0x33,0x44 -> cfg_word=0x44332211, cfg_ready=1, byte_cnt=4, cfg_err=0.
REQ-033 Valid rise sampled at edge k in LOAD -> byte_cnt increments at edge k+3, not k+2.
REQ-034 Full frame then a fifth byte 0x55 -> cfg_err=1, cfg_ready=0, byte_cnt=5, cfg_word still 0x44332211.
REQ-035 Start and valid pulses on the same edge, then 4 bytes -> only the 4 later bytes are stored; byte_cnt=4.
REQ-036 rst_n low after 2 bytes, then released with cfg_valid_async held high -> all outputs 0, FSM=IDLE, no byte captured.
REQ-037 Macro defined: bytes 0x11,0x22,0x33,0x44, then checksum 0x44 -> DONE; checksum 0x45 -> cfg_err=1.
